// File: rtl/waitstate_mem.sv
// waitstate_mem: request/response unified memory with programmable wait states and a post-reset clear engine
module waitstate_mem #(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 5,
  parameter int DEPTH          = 2**ADDR_W,
  parameter int WAIT_CYCLES    = 2,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              init_done_o
);
  typedef enum logic [1:0] {CLEAR, IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, addr_q, addr_d;
  logic [3:0] cnt_q, cnt_d;
  logic wr_q, wr_d, err_q, err_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic accept, commit, oob;
  assign accept = req_valid_i && state_q == IDLE;
  assign commit = state_q == WAIT && cnt_q == 4'd0;
  assign oob    = 32'(addr_q) >= DEPTH;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  always_comb begin
    state_d = state_q == CLEAR ? ((CLEAR_ON_RESET == 0 || ptr_q == ADDR_W'(DEPTH-1)) ? IDLE : CLEAR) :
              state_q == IDLE  ? (accept ? WAIT : IDLE) :
              state_q == WAIT  ? (commit ? RESP : WAIT) : IDLE;
    ptr_d   = state_q == CLEAR ? ptr_q + 1'b1 : ptr_q;
    cnt_d   = accept ? 4'(WAIT_CYCLES) : (state_q == WAIT && cnt_q != 4'd0) ? cnt_q - 1'b1 : cnt_q;
    wr_d    = accept ? req_write_i : wr_q;
    addr_d  = accept ? req_addr_i : addr_q;
    wdata_d = accept ? req_wdata_i : wdata_q;
    // Out-of-range accesses answer zero; reads of the array happen only here, into a register
    rdata_d = !commit ? rdata_q : oob ? '0 : wr_q ? wdata_q : mem_q[addr_q];
    err_d   = commit ? oob : err_q;
  end
  always_comb begin
    req_ready_o = state_q == IDLE;
    rsp_valid_o = state_q == RESP;
    init_done_o = state_q != CLEAR;
    rsp_rdata_o = rdata_q;
    rsp_err_o   = err_q;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      if (state_q == CLEAR && CLEAR_ON_RESET != 0) mem_q[ptr_q] <= '0;
      else if (commit && wr_q && !oob) mem_q[addr_q] <= wdata_q;
    end
endmodule
